// File: rtl/misr_pkg.sv
// Shared types and helpers for the parametrised MISR output response analyser.
// misr_next is the single definition of the signature update equation.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned MAX_W = 64;

  function automatic int unsigned cnt_width(input int unsigned patterns);
    return $clog2(patterns + 1);
  endfunction

  // Shift left, fold the old MSB back through the taps, then mix in the response word.
  // Operands are zero-extended to MAX_W; only the low 'width' bits of the result matter.
  function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] sig,
                                                 input logic [MAX_W-1:0] din,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int unsigned      width);
    logic                 msb;
    logic [MAX_W-1:0]     mask;
    msb  = sig[width-1];
    mask = (MAX_W'(1) << width) - MAX_W'(1);
    return ((sig << 1) ^ (poly & {MAX_W{msb}}) ^ din) & mask;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register: seed load, compaction enable, async active-low clear.
// The combinational next value is exported so the controller can judge the last word early.
module misr_core
  import misr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter int unsigned      IN_WIDTH = 2,
  parameter logic [WIDTH-1:0] POLY     = '0,
  parameter logic [WIDTH-1:0] SEED     = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_load,
  input  logic                i_enable,
  input  logic [IN_WIDTH-1:0] i_dataIn,
  output logic [WIDTH-1:0]    o_signature,
  output logic [WIDTH-1:0]    o_next
);

  logic [WIDTH-1:0] r_sig;

  assign o_next = WIDTH'(misr_next(MAX_W'(r_sig), MAX_W'(i_dataIn), MAX_W'(POLY), WIDTH));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sig <= '0;
    end else if (i_load) begin
      r_sig <= SEED;
    end else if (i_enable) begin
      r_sig <= o_next;
    end
  end

  assign o_signature = r_sig;

endmodule

// File: rtl/misr_ora_param.sv
// MISR output response analyser: compacts PATTERNS response words under a
// start/abort handshake and compares the final signature against GOLDEN.
module misr_ora_param
  import misr_pkg::*;
#(
  parameter int unsigned      WIDTH    = 4,
  parameter int unsigned      IN_WIDTH = 2,
  parameter                   POLY     = 4'b0011,
  parameter logic [WIDTH-1:0] SEED     = '0,
  parameter logic [WIDTH-1:0] GOLDEN   = WIDTH'(3),
  parameter int unsigned      PATTERNS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                dataValid,
  input  logic [IN_WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0]    signature,
  output logic                busy,
  output logic                done,
  output logic                pass
);

  localparam int unsigned    CW   = cnt_width(PATTERNS);
  localparam logic [CW-1:0]  LAST = CW'(PATTERNS - 1);

  if (WIDTH < 2 || WIDTH > MAX_W || IN_WIDTH < 1 || IN_WIDTH > WIDTH) begin : g_badWidth
    $error("misr_ora_param: need 2 <= WIDTH <= %0d and 1 <= IN_WIDTH <= WIDTH", MAX_W);
  end
  if (PATTERNS < 1) begin : g_badPatterns
    $error("misr_ora_param: PATTERNS must be at least 1");
  end
  if ($bits(POLY) != WIDTH) begin : g_badPoly
    $error("misr_ora_param: POLY must be exactly WIDTH bits wide");
  end

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [WIDTH-1:0] w_next;
  logic             w_load;
  logic             w_enable;

  // Abort wins over a coincident valid word, so the signature freezes on abort.
  assign w_load   = (r_state == IDLE || r_state == DONE) && start;
  assign w_enable = (r_state == COMPACT) && !abort && dataValid;

  misr_core #(
    .WIDTH   (WIDTH),
    .IN_WIDTH(IN_WIDTH),
    .POLY    (WIDTH'(POLY)),
    .SEED    (SEED)
  ) u_core (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_enable   (w_enable),
    .i_dataIn   (dataIn),
    .o_signature(signature),
    .o_next     (w_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= COMPACT;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        COMPACT: begin
          if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (dataValid) begin
            if (r_count == LAST) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_next == GOLDEN);
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign pass = r_pass;

endmodule

// File: tb/tb_misr_ora_param.sv
// Directed bench for misr_ora_param: default 4-bit instance with hand-computed
// signatures plus an 8-bit instance tracked against misr_next.
module tb_misr_ora_param;
  import misr_pkg::*;

  localparam logic [7:0] POLY_B   = 8'h1D;
  localparam logic [7:0] SEED_B   = 8'hA5;
  localparam logic [7:0] GOLDEN_B = 8'h5A;

  logic       clock = 1'b0;
  logic       reset;
  logic       start, abort, dataValid;
  logic [1:0] dataIn;
  logic [3:0] sigA;
  logic       busyA, doneA, passA;

  logic       startB, abortB, dvB;
  logic [2:0] dinB;
  logic [7:0] sigB;
  logic       busyB, doneB, passB;

  int nChecks = 0;
  int nBad    = 0;

  always #5 clock = ~clock;

  misr_ora_param dutA (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .dataValid(dataValid),
    .dataIn   (dataIn),
    .signature(sigA),
    .busy     (busyA),
    .done     (doneA),
    .pass     (passA)
  );

  misr_ora_param #(
    .WIDTH   (8),
    .IN_WIDTH(3),
    .POLY    (POLY_B),
    .SEED    (SEED_B),
    .GOLDEN  (GOLDEN_B),
    .PATTERNS(16)
  ) dutB (
    .clock    (clock),
    .reset    (reset),
    .start    (startB),
    .abort    (abortB),
    .dataValid(dvB),
    .dataIn   (dinB),
    .signature(sigB),
    .busy     (busyB),
    .done     (doneB),
    .pass     (passB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkA(input string tag, input logic b, input logic d, input logic p, input logic [3:0] s);
    checkOutput(tag, 32'({busyA, doneA, passA, sigA}), 32'({b, d, p, s}));
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic dv, input logic [1:0] d);
    start     = s;
    abort     = a;
    dataValid = dv;
    dataIn    = d;
    @(posedge clock);
    #1;
  endtask

  // One full 16-word run on the wide instance with random stalls; starting from DONE chains runs.
  task automatic runB();
    logic [7:0] model;
    int         cnt;
    int         cyc;
    startB = 1'b1;
    dvB    = 1'b0;
    @(posedge clock);
    #1;
    startB = 1'b0;
    model  = SEED_B;
    cnt    = 0;
    cyc    = 0;
    checkOutput("B start", 32'({busyB, doneB, sigB}), 32'({1'b1, 1'b0, model}));
    while (cnt < 16 && cyc < 200) begin
      dvB  = ($urandom_range(0, 3) != 0);
      dinB = 3'($urandom);
      @(posedge clock);
      #1;
      cyc++;
      if (dvB) begin
        model = 8'(misr_next(MAX_W'(model), MAX_W'(dinB), MAX_W'(POLY_B), 8));
        cnt++;
      end
      checkOutput("B sig", 32'({doneB, sigB}), 32'({(cnt == 16), model}));
    end
    dvB = 1'b0;
    checkOutput("B result", 32'({busyB, doneB, passB}), 32'({1'b0, 1'b1, (model == GOLDEN_B)}));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0; abort = 1'b0; dataValid = 1'b0; dataIn = 2'b00;
    startB = 1'b0; abortB = 1'b0; dvB = 1'b0; dinB = 3'b000;
    #3;
    checkA("reset values", 0, 0, 0, 4'b0000);
    checkOutput("reset B", 32'({busyB, doneB, passB, sigB}), 32'(0));
    #9 reset = 1'b1;
    applyStimulus(0, 0, 0, 2'b00);
    checkA("idle", 0, 0, 0, 4'b0000);

    // Scenario 1: 00,01,10,11 -> 0000,0001,0000,0011, pass
    applyStimulus(1, 0, 0, 2'b00); checkA("s1 start", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 1, 2'b00); checkA("s1 w0", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 1, 2'b01); checkA("s1 w1", 1, 0, 0, 4'b0001);
    applyStimulus(0, 0, 1, 2'b10); checkA("s1 w2", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 1, 2'b11); checkA("s1 done", 0, 1, 1, 4'b0011);
    applyStimulus(0, 1, 1, 2'b10); checkA("s1 hold", 0, 1, 1, 4'b0011);

    // Scenario 2: restart from DONE, 11 x4 -> 0011,0101,1001,0010, fail
    applyStimulus(1, 0, 0, 2'b00); checkA("s2 restart", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 1, 2'b11); checkA("s2 w0", 1, 0, 0, 4'b0011);
    applyStimulus(0, 0, 1, 2'b11); checkA("s2 w1", 1, 0, 0, 4'b0101);
    applyStimulus(0, 0, 1, 2'b11); checkA("s2 w2", 1, 0, 0, 4'b1001);
    applyStimulus(0, 0, 1, 2'b11); checkA("s2 done", 0, 1, 0, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 2'b01);
      checkA("s2 hold", 0, 1, 0, 4'b0010);
    end

    // Scenario 3: scenario 1 data with stalls of 1 and 3 cycles
    applyStimulus(1, 0, 0, 2'b00); checkA("s3 start", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 1, 2'b00); checkA("s3 w0", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 0, 2'b11); checkA("s3 gap1", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 1, 2'b01); checkA("s3 w1", 1, 0, 0, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 2'b10);
      checkA("s3 gap3", 1, 0, 0, 4'b0001);
    end
    applyStimulus(0, 0, 1, 2'b10); checkA("s3 w2", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 1, 2'b11); checkA("s3 done", 0, 1, 1, 4'b0011);

    // Scenario 4: abort with a coincident valid word
    applyStimulus(1, 0, 0, 2'b00); checkA("s4 start", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 1, 2'b00); checkA("s4 w0", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 1, 2'b01); checkA("s4 w1", 1, 0, 0, 4'b0001);
    applyStimulus(0, 1, 1, 2'b10); checkA("s4 abort", 0, 0, 0, 4'b0001);
    applyStimulus(0, 0, 1, 2'b11); checkA("s4 idle data", 0, 0, 0, 4'b0001);
    applyStimulus(1, 0, 0, 2'b00); checkA("s4 reseed", 1, 0, 0, 4'b0000);
    applyStimulus(1, 0, 1, 2'b01); checkA("s4 start ignored", 1, 0, 0, 4'b0001);

    // Scenario 5: asynchronous reset between edges mid-run
    #3 reset = 1'b0;
    #1 checkA("s5 async reset", 0, 0, 0, 4'b0000);
    start = 1'b1; dataValid = 1'b1; dataIn = 2'b11;
    @(posedge clock);
    #1 checkA("s5 held in reset", 0, 0, 0, 4'b0000);
    #3;
    start = 1'b0; dataValid = 1'b0;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 2'b00); checkA("s5 idle after", 0, 0, 0, 4'b0000);
    applyStimulus(1, 0, 0, 2'b00); checkA("s5 start", 1, 0, 0, 4'b0000);
    applyStimulus(0, 0, 1, 2'b11); checkA("s5 w0", 1, 0, 0, 4'b0011);
    applyStimulus(0, 0, 0, 2'b00);

    // Scenario 6: wide instance, two back-to-back runs
    runB();
    runB();

    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end

endmodule

// File: doc/misr_ora_param.md
# misr_ora_param

Parametrised multiple-input signature register (MISR) output response analyser for the BIST datapath. It compacts a programmable number of circuit-under-test response words into a WIDTH-bit signature and compares the final signature against a golden value. It reports done/pass under a start/abort handshake. It sits between the CUT outputs (e.g. the full adder's {Cout, Sum}) and the BIST controller, replacing the fixed 4-bit, free-running ORA.

## Interface
- WIDTH, 4, signature width; must be ≥ 2 and ≥ IN_WIDTH
- IN_WIDTH, 2, response word width; bit i feeds MISR stage i
- POLY, 4'b0011, feedback taps; POLY[i]=1 XORs sig[WIDTH-1] into stage i (default x^4+x+1)
- SEED, 0, signature value loaded on start
- GOLDEN, 4'b0011, expected final signature
- PATTERNS, 4, number of valid response words compacted per run; must be ≥ 1
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; reset=0 forces reset state immediately
- start  in  1  begin a run; sampled in IDLE and DONE only
- abort  in  1  cancel a run in progress; sampled in COMPACT only
- dataValid  in  1  dataIn is a response word to compact this cycle
- dataIn  in  IN_WIDTH  CUT response word
- signature  out  WIDTH  current MISR contents
- busy  out  1  high in COMPACT
- done  out  1  high in DONE
- pass  out  1  result of the golden compare; meaningful only while done=1

## Operation
- MISR next state: nxt[i] = (i==0 ? 0 : sig[i-1]) ^ (POLY[i] & sig[WIDTH-1]) ^ (i<IN_WIDTH ? dataIn[i] : 0).
- Pattern counter width is $clog2(PATTERNS+1). It is unsigned and never wraps within a run.
- FSM states are IDLE, COMPACT and DONE.
- IDLE, start=1: signature←SEED, count←0, go to COMPACT.
- COMPACT, abort=1: go to IDLE. signature holds its value, and done and pass stay 0. Abort has priority over dataValid in the same cycle.
- COMPACT, dataValid=1, count<PATTERNS-1: signature←nxt, count++.
- COMPACT, dataValid=1, count==PATTERNS-1: signature←nxt, pass←(nxt==GOLDEN), go to DONE.
- COMPACT, dataValid=0: everything holds. Stalls of any length are allowed.
- DONE: signature, pass and done hold. start=1 re-seeds and goes to COMPACT in one edge, with done and pass cleared on that edge.
- start in COMPACT is ignored. abort outside COMPACT is ignored. dataValid outside COMPACT is ignored and the signature does not change.
- Reset values: state=IDLE, signature=0, count=0, busy=0, done=0, pass=0. All outputs are registered or decoded from registered state only.
- Reset mid-run aborts the run immediately. No result is reported.

## Timing
- start sampled at edge k: busy=1 and signature=SEED after k. The first response word can be sampled at edge k+1.
- With continuous dataValid, done=1 after edge k+PATTERNS, so latency from start is PATTERNS+1 cycles.
- done and pass rise on the same edge as the last compaction. There is no extra compare cycle.
- busy and done are never both high.
- Asynchronous reset assertion clears outputs without a clock. Deassertion is synchronised externally. The first active edge after deassertion sees IDLE.

## Structure
- Package misr_pkg holds:
  - the state enum (IDLE, COMPACT, DONE);
  - a localparam helper for the counter width;
  - a function misr_next(sig, din, poly) implementing the update equation. The bench model reuses this function.
- One sub-module, misr_core: a parametrised WIDTH/IN_WIDTH/POLY signature register with load (SEED), enable and async active-low clear. The FSM and counter live in misr_ora_param.
- Elaboration-time checks cover IN_WIDTH ≤ WIDTH, PATTERNS ≥ 1 and the width of POLY.

## Test plan
- Defaults; start, then dataIn 00, 01, 10, 11 with dataValid held high → signature sequence 0000, 0001, 0000, 0011; done=1, pass=1 one cycle after the fourth sample; busy falls on that same edge.
- Defaults; dataIn 11 ×4 → signature 0011, 0101, 1001, 0010; done=1, pass=0, signature holds 0010 in DONE for 5+ cycles.
- Defaults; same data as scenario 1 with dataValid=0 gaps of 1 and 3 cycles → identical final signature 0011, pass=1, and the signature is stable during the gaps.
- Abort after 2 samples (signature=0001 on scenario 1 data), with dataValid=1 in the abort cycle → IDLE, signature stays 0001, done=0; a subsequent start re-seeds to 0000.
- reset=0 asserted between clock edges mid-COMPACT → all outputs 0 immediately; start and data ignored while reset=0.
- WIDTH=8, IN_WIDTH=3, POLY=8'h1D, PATTERNS=16, random data → signature matches the misr_pkg reference model every cycle; restarting with start in DONE gives back-to-back runs.
